// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-ported register file with two read ports, two write ports,
// same-cycle write bypass and a sequential clear engine.
module reg_file_mp #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [DATA_W-1:0] read_a,
    output logic [DATA_W-1:0] read_b,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              we1,
    input  logic              clr_req,
    output logic              busy,
    output logic              wr_conflict
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr0, wr1;

    assign busy = state == CLEAR;

    // Effective enables: ports are muted during a clear and at a hardwired zero register
    assign wr0 = we0 && !busy && !(ZERO_REG != 0 && wa0 == '0);
    assign wr1 = we1 && !busy && !(ZERO_REG != 0 && wa1 == '0);

    assign read_a = (ZERO_REG != 0 && ra == '0)      ? '0  :
                    (BYPASS != 0 && wr1 && wa1 == ra) ? wd1 :
                    (BYPASS != 0 && wr0 && wa0 == ra) ? wd0 : mem[ra];
    assign read_b = (ZERO_REG != 0 && rb == '0)      ? '0  :
                    (BYPASS != 0 && wr1 && wa1 == rb) ? wd1 :
                    (BYPASS != 0 && wr0 && wa0 == rb) ? wd0 : mem[rb];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_conflict <= 1'b0;
        end else begin
            wr_conflict <= wr0 && wr1 && wa0 == wa1;
            if (busy) mem[ptr] <= '0;
            if (wr0) mem[wa0] <= wd0;
            if (wr1) mem[wa1] <= wd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        if (state == IDLE) begin
            if (clr_req) begin
                state_nxt = CLEAR;
                ptr_nxt   = '0;
            end
        end else begin
            ptr_nxt = ptr + 1'b1;
            if (ptr == ADDR_W'(DEPTH - 1)) state_nxt = IDLE;
        end
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed checks of reg_file_mp in default, no-bypass and
// zero-register configurations driven by shared stimulus.
module tb_reg_file_mp;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ra, rb, wa0, wa1;
    logic [7:0] wd0, wd1;
    logic       we0, we1, clr_req;
    logic [7:0] read_a, read_b, nb_read_a, nb_read_b, z_read_a, z_read_b;
    logic       busy, wr_conflict, nb_busy, nb_wr_conflict, z_busy, z_wr_conflict;
    int         n_checks = 0;
    int         n_fail = 0;
    int         n;

    always #5 clk = ~clk;

    reg_file_mp dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb), .read_a(read_a), .read_b(read_b),
        .wa0(wa0), .wd0(wd0), .we0(we0), .wa1(wa1), .wd1(wd1), .we1(we1),
        .clr_req(clr_req), .busy(busy), .wr_conflict(wr_conflict)
    );

    reg_file_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb), .read_a(nb_read_a), .read_b(nb_read_b),
        .wa0(wa0), .wd0(wd0), .we0(we0), .wa1(wa1), .wd1(wd1), .we1(we1),
        .clr_req(clr_req), .busy(nb_busy), .wr_conflict(nb_wr_conflict)
    );

    reg_file_mp #(.ZERO_REG(1)) dut_z (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb), .read_a(z_read_a), .read_b(z_read_b),
        .wa0(wa0), .wd0(wd0), .we0(we0), .wa1(wa1), .wd1(wd1), .we1(we1),
        .clr_req(clr_req), .busy(z_busy), .wr_conflict(z_wr_conflict)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < 16; i++) begin
            we0 = 1'b1;
            wa0 = 4'(i);
            wd0 = base + 8'(i);
            tick();
        end
        we0 = 1'b0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        {ra, rb, wa0, wa1, wd0, wd1, we0, we1, clr_req} = '0;
        rst_n = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_conflict", wr_conflict, 0);
        check("rst_read", read_a, 0);
        rst_n = 1'b1;
        we0 = 1'b1; wa0 = 4'd7; wd0 = 8'h99;
        tick();
        we0 = 1'b0; ra = 4'd7;
        #1 check("first_wr", read_a, 8'h99);

        for (int i = 0; i < 16; i++) begin
            we0 = 1'b1; wa0 = 4'(i); wd0 = 8'(i * 17);
            tick();
        end
        we0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ra = 4'(i); rb = 4'(15 - i);
            #1;
            check("sweep_a", read_a, i * 17);
            check("sweep_b", read_b, (15 - i) * 17);
        end

        ra = 4'd0; rb = 4'd0; we0 = 1'b1; wa0 = 4'd0; wd0 = 8'h77;
        #1;
        check("z_no_bypass", z_read_a, 0);
        check("bypass_a0", read_a, 8'h77);
        tick();
        we0 = 1'b0;
        #1;
        check("z_read_a", z_read_a, 0);
        check("z_read_b", z_read_b, 0);
        check("wr_a0", read_b, 8'h77);

        we0 = 1'b1; we1 = 1'b1; wa0 = 4'd3; wa1 = 4'd3; wd0 = 8'h55; wd1 = 8'hAA; ra = 4'd3;
        #1;
        check("bypass_prio", read_a, 8'hAA);
        check("pre_conflict", wr_conflict, 0);
        tick();
        we0 = 1'b0; we1 = 1'b0;
        #1;
        check("conflict", wr_conflict, 1);
        check("conflict_data", read_a, 8'hAA);
        tick();
        check("conflict_drop", wr_conflict, 0);

        we0 = 1'b1; we1 = 1'b1; wa0 = 4'd0; wa1 = 4'd0; wd0 = 8'h11; wd1 = 8'h22; ra = 4'd0;
        #1 check("z_bypass0", z_read_a, 0);
        tick();
        we0 = 1'b0; we1 = 1'b0;
        #1;
        check("z_conflict", z_wr_conflict, 0);
        check("conflict0", wr_conflict, 1);
        check("wr_p1_a0", read_a, 8'h22);

        ra = 4'd5; we0 = 1'b1; wa0 = 4'd5; wd0 = 8'h3C;
        #1;
        check("bypass", read_a, 8'h3C);
        check("no_bypass", nb_read_a, 8'h55);
        we1 = 1'b1; wa1 = 4'd5; wd1 = 8'hC3;
        #1;
        check("bypass_p1", read_a, 8'hC3);
        check("no_bypass_p1", nb_read_a, 8'h55);
        tick();
        we0 = 1'b0; we1 = 1'b0;
        #1;
        check("bypass_commit", read_a, 8'hC3);
        check("nb_commit", nb_read_a, 8'hC3);

        clr_req = 1'b1; we0 = 1'b1; wa0 = 4'd9; wd0 = 8'h5A;
        tick();
        clr_req = 1'b0;
        we0 = 1'b1; we1 = 1'b1; wa0 = 4'd2; wa1 = 4'd2; wd0 = 8'hFF; wd1 = 8'hFF;
        ra = 4'd9; rb = 4'd2;
        #1;
        check("clr_start_wr", read_a, 8'h5A);
        check("busy_rd_nobypass", read_b, 8'h22);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
            if (n == 1) begin
                check("busy_no_conflict", wr_conflict, 0);
                we0 = 1'b0; we1 = 1'b0;
            end
        end
        check("busy_len", n, 16);
        for (int i = 0; i < 16; i++) begin
            ra = 4'(i);
            #1 check("cleared", read_a, 0);
        end

        fill(8'hA0);
        clr_req = 1'b1;
        tick();
        check("held_busy", busy, 1);
        wait_idle(n);
        check("held_len", n, 16);
        tick();
        check("held_restart", busy, 1);
        clr_req = 1'b0;
        wait_idle(n);
        check("restart_len", n, 16);

        fill(8'hA0);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (5) tick();
        ra = 4'd15;
        #1 check("pre_rst", read_a, 8'hAF);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_async", read_a, 0);
        #3 rst_n = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);
        for (int i = 0; i < 16; i++) begin
            ra = 4'(i);
            #1 check("post_rst_zero", read_a, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 8, data width of every register in bits.
REQ-002 Parameter ADDR_W, default 4, address width; register count DEPTH = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 0, when 1 register 0 is hardwired to zero.
REQ-004 Parameter BYPASS, default 1, when 1 same-cycle write data is forwarded to reads.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 ra  input  ADDR_W  read port A address.
REQ-008 rb  input  ADDR_W  read port B address.
REQ-009 read_a  output  DATA_W  read port A data.
REQ-010 read_b  output  DATA_W  read port B data.
REQ-011 wa0 / wd0 / we0  input  ADDR_W / DATA_W / 1  write port 0 address, data, enable.
REQ-012 wa1 / wd1 / we1  input  ADDR_W / DATA_W / 1  write port 1 address, data, enable.
REQ-013 clr_req  input  1  request to clear all registers sequentially.
REQ-014 busy  output  1  high while a sequential clear is in progress.
REQ-015 wr_conflict  output  1  registered flag, high for one cycle after a same-address double write.

Function
REQ-016 Reads SHALL be combinational: read_x = mem[rx] with zero added latency.
REQ-017 Writes SHALL commit on the rising clk edge where the port's enable is high.
REQ-018 If we0 and we1 target the same address in one cycle, port 1 data SHALL be stored and wr_conflict SHALL be 1 in the following cycle only.
REQ-019 With BYPASS=1, a read whose address matches an enabled write address in the same cycle SHALL return that write data, port 1 taking priority over port 0.
REQ-020 With BYPASS=0, reads SHALL return the pre-edge stored value.
REQ-021 With ZERO_REG=1, reads of address 0 SHALL return 0 on both ports, writes to address 0 SHALL be discarded, bypass to address 0 SHALL not occur, and no wr_conflict SHALL be flagged for address 0.
REQ-022 Clear FSM SHALL have states IDLE and CLEAR, with pointer ptr of ADDR_W bits.
REQ-023 In IDLE, clr_req=1 at a rising edge SHALL move to CLEAR with ptr=0; writes in that same cycle SHALL still commit.
REQ-024 In CLEAR, each rising edge SHALL write 0 to mem[ptr] and increment ptr; at the edge with ptr=DEPTH-1 the FSM SHALL return to IDLE.
REQ-025 busy SHALL equal (state==CLEAR), so busy is high for exactly DEPTH cycles per clear.
REQ-026 While busy, both write ports SHALL be ignored, without wr_conflict, and clr_req SHALL be ignored.
REQ-027 While busy, reads SHALL return current stored contents (cleared entries read 0), with no bypass.
REQ-028 clr_req held high continuously SHALL start a new clear on the first IDLE edge after each completed clear.

Reset
REQ-029 rst_n=0 SHALL asynchronously set every register to 0, state to IDLE, ptr to 0, busy to 0 and wr_conflict to 0.
REQ-030 Reset asserted mid-clear SHALL abort the clear immediately; after release the FSM SHALL be IDLE and all registers 0.
REQ-031 The first write after reset release SHALL be accepted at the first rising edge where rst_n=1.

Verification
REQ-032 Defaults; write i*8'h11 to address i for i=0..15 via port 0, then sweep ra=i, rb=15-i -> read_a=i*8'h11, read_b=(15-i)*8'h11.
REQ-033 we0=we1=1, wa0=wa1=3, wd0=8'h55, wd1=8'hAA -> mem[3]=8'hAA, wr_conflict=1 for one cycle, then 0.
REQ-034 BYPASS=1, ra=5, we0=1, wa0=5, wd0=8'h3C in the same cycle -> read_a=8'h3C before the edge; BYPASS=0 -> the old value is returned.
REQ-035 All registers non-zero, pulse clr_req -> busy high 16 cycles; a write of 8'hFF to address 2 during busy is dropped; afterwards all 16 registers read 0.
REQ-036 ZERO_REG=1, write 8'h77 to address 0 -> read_a=read_b=0 with ra=rb=0.
REQ-037 Assert rst_n=0 after 5 clear cycles -> busy=0 immediately, all registers read 0 after release.
